// File: rtl/mac_sequencer_pkg.sv
// Shared definitions for mac_sequencer: FSM state encoding, default parameters
// and the counter-width helper used by the top level.
package mac_sequencer_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_MUL_LAT = 1;

  // 3-bit binary state encoding; the values are visible on the state_dbg port.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MUL_AB = 3'd1,
    S_MUL_CD = 3'd2,
    S_ADD    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // The per-product counter runs 0..mul_lat, so it needs room for mul_lat+1.
  function automatic int cnt_width(input int mul_lat);
    return $clog2(mul_lat + 2);
  endfunction

endpackage

// File: rtl/mac_sequencer_mult_pipe.sv
// mult_pipe: unsigned WIDTH x WIDTH multiplier followed by MUL_LAT register stages.
// The data path has no reset; the controlling FSM decides when the output is meaningful.
module mult_pipe #(
  parameter int WIDTH   = 8,
  parameter int MUL_LAT = 1
) (
  input  logic                 clk,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic [2*WIDTH-1:0]   product
);

  logic [2*WIDTH-1:0] stage [MUL_LAT];

  always_ff @(posedge clk) begin
    stage[0] <= {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, y};
    for (int i = 1; i < MUL_LAT; i++) begin
      stage[i] <= stage[i-1];
    end
  end

  assign product = stage[MUL_LAT-1];

endmodule

// File: rtl/mac_sequencer.sv
// mac_sequencer: computes sum = a*b + c*d with one shared multiplier and a control FSM.
// Build option: define MAC_SATURATE_EN to clamp sum to all ones on carry out (default wraps).
module mac_sequencer
  import mac_sequencer_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MUL_LAT = DEF_MUL_LAT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 clear,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     c,
  input  logic [WIDTH-1:0]     d,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   sum,
  output logic                 overflow,
  output logic [2:0]           state_dbg
);

  // Handshake: start is accepted only on an edge where the FSM is idle (busy=0) and
  // clear is low; starts seen while busy (including the done cycle) are dropped, not
  // queued. done pulses for one cycle when sum/overflow take their new value, and
  // the result holds until the next completion, clear or reset.

  localparam int             CW       = cnt_width(MUL_LAT);
  localparam logic [CW-1:0]  CNT_LAST = CW'(MUL_LAT);

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [WIDTH-1:0]     ra, rb, rc, rd;
  logic [2*WIDTH-1:0]   p0, p1;
  logic [2*WIDTH-1:0]   product;
  logic [WIDTH-1:0]     mul_x, mul_y;
  logic [2*WIDTH:0]     total;
  logic [2*WIDTH-1:0]   sum_next;

  // Operand pair A,B is presented everywhere except MUL_CD.
  always_comb begin
    mul_x = ra;
    mul_y = rb;
    if (state == S_MUL_CD) begin
      mul_x = rc;
      mul_y = rd;
    end
  end

  always_comb begin
    total = {1'b0, p0} + {1'b0, p1};
`ifdef MAC_SATURATE_EN
    sum_next = total[2*WIDTH] ? {(2*WIDTH){1'b1}} : total[2*WIDTH-1:0];
`else
    sum_next = total[2*WIDTH-1:0];
`endif
  end

  mult_pipe #(
    .WIDTH   (WIDTH),
    .MUL_LAT (MUL_LAT)
  ) u_mult (
    .clk     (clk),
    .x       (mul_x),
    .y       (mul_y),
    .product (product)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      ra       <= '0;
      rb       <= '0;
      rc       <= '0;
      rd       <= '0;
      p0       <= '0;
      p1       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      state    <= S_IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            ra    <= a;
            rb    <= b;
            rc    <= c;
            rd    <= d;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_MUL_AB;
          end
        end
        // The pipe output is valid for the current pair on the last counted cycle.
        S_MUL_AB: begin
          if (cnt == CNT_LAST) begin
            p0    <= product;
            cnt   <= '0;
            state <= S_MUL_CD;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_MUL_CD: begin
          if (cnt == CNT_LAST) begin
            p1    <= product;
            cnt   <= '0;
            state <= S_ADD;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_ADD: begin
          sum      <= sum_next;
          overflow <= total[2*WIDTH];
          done     <= 1'b1;
          state    <= S_DONE;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer: MUL_LAT=1 instance for the main scenarios and a
// MUL_LAT=3 instance for the longer-latency case; results are checked by done monitors.
module tb_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, clear;
  logic [7:0]  a, b, c, d;
  logic        busy, done, overflow;
  logic [15:0] sum;
  logic [2:0]  state_dbg;

  logic        start3, clear3;
  logic [7:0]  a3, b3, c3, d3;
  logic        busy3, done3, overflow3;
  logic [15:0] sum3;
  logic [2:0]  state_dbg3;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [16:0] exp_q[$];
  int          exp_t_q[$];
  logic [16:0] exp3_q[$];
  int          exp3_t_q[$];
  logic [16:0] mon_e, mon3_e;
  int          mon_t, mon3_t;

  mac_sequencer #(.WIDTH(8), .MUL_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear),
    .a(a), .b(b), .c(c), .d(d),
    .busy(busy), .done(done), .sum(sum), .overflow(overflow), .state_dbg(state_dbg)
  );

  mac_sequencer #(.WIDTH(8), .MUL_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .clear(clear3),
    .a(a3), .b(b3), .c(c3), .d(d3),
    .busy(busy3), .done(done3), .sum(sum3), .overflow(overflow3), .state_dbg(state_dbg3)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drives one start pulse; when expect_done is set, queues the hand-computed result.
  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] ic,
                       input logic [7:0] id, input logic [15:0] es, input logic eo,
                       input bit expect_done);
    @(negedge clk);
    a = ia; b = ib; c = ic; d = id;
    start = 1'b1;
    if (expect_done) begin
      exp_q.push_back({eo, es});
      exp_t_q.push_back(cyc + 6);
    end
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, busy}, 32'd0);
  endtask

  // Scoreboard monitors: pop an expectation whenever done is seen.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, required 0", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        mon_t = exp_t_q.pop_front();
        check("result", {15'd0, overflow, sum}, {15'd0, mon_e});
        check("done_cycle", cyc, mon_t);
      end
    end
  end

  always @(negedge clk) begin
    if (done3 === 1'b1) begin
      if (exp3_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done3: done3=1 at cycle %0d, required 0", cyc);
      end else begin
        mon3_e = exp3_q.pop_front();
        mon3_t = exp3_t_q.pop_front();
        check("result3", {15'd0, overflow3, sum3}, {15'd0, mon3_e});
        check("done_cycle3", cyc, mon3_t);
      end
    end
  end

  initial begin
    int n0;
    int n;
    logic [15:0] ff_sum, edge_sum;
    rst = 1'b1; start = 1'b0; clear = 1'b0;
    a = '0; b = '0; c = '0; d = '0;
    start3 = 1'b0; clear3 = 1'b0;
    a3 = '0; b3 = '0; c3 = '0; d3 = '0;
`ifdef MAC_SATURATE_EN
    ff_sum   = 16'hFFFF;
    edge_sum = 16'hFFFF;
`else
    ff_sum   = 16'hFC02;
    edge_sum = 16'h0000;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum", {16'd0, sum}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_state", {29'd0, state_dbg}, 32'd0);
    rst = 1'b0;

    // Basic products and overflow boundaries
    issue(8'd3, 8'd4, 8'd5, 8'd6, 16'h002A, 1'b0, 1);
    wait_idle("idle_t1");
    check("sum_hold_t1", {16'd0, sum}, 32'h2A);
    issue(8'hFF, 8'hFF, 8'hFF, 8'hFF, ff_sum, 1'b1, 1);
    wait_idle("idle_t2");
    issue(8'hFF, 8'hFF, 8'h02, 8'hFF, 16'hFFFF, 1'b0, 1);
    wait_idle("idle_max_no_carry");
    issue(8'hFF, 8'hFF, 8'h07, 8'h49, edge_sum, 1'b1, 1);
    wait_idle("idle_min_carry");

    // Start held 20 cycles, operands changed in cycle 2
    @(negedge clk);
    a = 8'd1; b = 8'd2; c = 8'd3; d = 8'd4;
    start = 1'b1;
    n0 = cyc;
    exp_q.push_back({1'b0, 16'h000E}); exp_t_q.push_back(n0 + 6);
    exp_q.push_back({1'b0, 16'h0056}); exp_t_q.push_back(n0 + 13);
    exp_q.push_back({1'b0, 16'h0056}); exp_t_q.push_back(n0 + 20);
    repeat (2) @(negedge clk);
    a = 8'd5; b = 8'd6; c = 8'd7; d = 8'd8;
    n = 0;
    while (cyc < n0 + 20 && n < 40) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    wait_idle("idle_t3");

    // Reset in cycle 3 of an operation
    issue(8'd1, 8'd1, 8'd1, 8'd1, 16'h0, 1'b0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_sum", {16'd0, sum}, 32'd0);
    check("midrst_ovf", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("midrst_idle", {31'd0, busy}, 32'd0);

    // Clear mid-operation discards the result
    issue(8'd3, 8'd4, 8'd5, 8'd6, 16'h002A, 1'b0, 1);
    wait_idle("idle_pre_clear");
    issue(8'd9, 8'd9, 8'd9, 8'd9, 16'h0, 1'b0, 0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("midclr_busy", {31'd0, busy}, 32'd0);
    check("midclr_sum", {16'd0, sum}, 32'd0);
    check("midclr_state", {29'd0, state_dbg}, 32'd0);
    repeat (10) @(negedge clk);
    check("midclr_idle", {31'd0, busy}, 32'd0);

    // Clear and start together in IDLE
    issue(8'd3, 8'd4, 8'd5, 8'd6, 16'h002A, 1'b0, 1);
    wait_idle("idle_t5");
    check("sum_before_clr", {16'd0, sum}, 32'h2A);
    @(negedge clk);
    clear = 1'b1; start = 1'b1;
    @(negedge clk);
    clear = 1'b0; start = 1'b0;
    check("clrstart_sum", {16'd0, sum}, 32'd0);
    check("clrstart_ovf", {31'd0, overflow}, 32'd0);
    check("clrstart_busy", {31'd0, busy}, 32'd0);
    check("clrstart_state", {29'd0, state_dbg}, 32'd0);
    repeat (3) @(negedge clk);
    check("clrstart_stay", {31'd0, busy}, 32'd0);

    // MUL_LAT=3 instance
    @(negedge clk);
    a3 = 8'd2; b3 = 8'd3; c3 = 8'd4; d3 = 8'd5;
    start3 = 1'b1;
    exp3_q.push_back({1'b0, 16'h001A});
    exp3_t_q.push_back(cyc + 10);
    @(negedge clk);
    start3 = 1'b0;
    check("busy3_after_start", {31'd0, busy3}, 32'd1);
    n = 0;
    while (busy3 !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle3", {31'd0, busy3}, 32'd0);

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    check("queue3_empty", exp3_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
